// File: rtl/stream_pkg.sv
// Shared constants and types for the two-input stream merge arbiter.
// Optional build macro: STREAM_MERGE_SRC_TAG_EN (adds the out0_data_src output).
package stream_pkg;

   localparam int DATA_WIDTH_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_EMIT_EOS = 2'd2,
      ST_DONE     = 2'd3
   } merge_state_e;

endpackage

// File: rtl/stream_merge_arbiter_if.sv
// Handshake bundle for the merge arbiter: start/completion tokens, two input streams, merged output.
// Build macro STREAM_MERGE_SRC_TAG_EN adds out0_data_src to the bundle.
interface stream_merge_arbiter_if
   import stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

   logic                  inCtrl_valid;
   logic                  inCtrl_ready;
   logic                  outCtrl_valid;
   logic                  outCtrl_ready;
   logic                  in0_valid;
   logic                  in0_ready;
   logic [DATA_WIDTH-1:0] in0_data_field0;
   logic                  in0_data_field1;
   logic                  in1_valid;
   logic                  in1_ready;
   logic [DATA_WIDTH-1:0] in1_data_field0;
   logic                  in1_data_field1;
   logic                  out0_valid;
   logic                  out0_ready;
   logic [DATA_WIDTH-1:0] out0_data_field0;
   logic                  out0_data_field1;
`ifdef STREAM_MERGE_SRC_TAG_EN
   logic                  out0_data_src;

   modport master (
      output inCtrl_valid, input inCtrl_ready,
      input outCtrl_valid, output outCtrl_ready,
      output in0_valid, input in0_ready, output in0_data_field0, output in0_data_field1,
      output in1_valid, input in1_ready, output in1_data_field0, output in1_data_field1,
      input out0_valid, output out0_ready, input out0_data_field0, input out0_data_field1,
      input out0_data_src
   );

   modport slave (
      input inCtrl_valid, output inCtrl_ready,
      output outCtrl_valid, input outCtrl_ready,
      input in0_valid, output in0_ready, input in0_data_field0, input in0_data_field1,
      input in1_valid, output in1_ready, input in1_data_field0, input in1_data_field1,
      output out0_valid, input out0_ready, output out0_data_field0, output out0_data_field1,
      output out0_data_src
   );
`else
   modport master (
      output inCtrl_valid, input inCtrl_ready,
      input outCtrl_valid, output outCtrl_ready,
      output in0_valid, input in0_ready, output in0_data_field0, output in0_data_field1,
      output in1_valid, input in1_ready, output in1_data_field0, output in1_data_field1,
      input out0_valid, output out0_ready, input out0_data_field0, input out0_data_field1
   );

   modport slave (
      input inCtrl_valid, output inCtrl_ready,
      output outCtrl_valid, input outCtrl_ready,
      input in0_valid, output in0_ready, input in0_data_field0, input in0_data_field1,
      input in1_valid, output in1_ready, input in1_data_field0, input in1_data_field1,
      output out0_valid, input out0_ready, output out0_data_field0, output out0_data_field1
   );
`endif

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the priority pointer moves past the winner only on an accept.
module rr_arbiter2 (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       grant
);

   logic prio_reg;

   // Priority input wins when it requests; otherwise a lone other requester takes the grant.
   always_comb begin
      grant = prio_reg;
      if (!req[prio_reg] && req[!prio_reg]) begin
         grant = !prio_reg;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prio_reg <= 1'b0;
      end else if (clear) begin
         prio_reg <= 1'b0;
      end else if (accept) begin
         prio_reg <= !grant;
      end
   end

endmodule

// File: rtl/stream_merge_arbiter.sv
// Merges two EOS-terminated streams into one through a single output register, one EOS per run.
// Build macro STREAM_MERGE_SRC_TAG_EN registers the source index alongside each output beat.
module stream_merge_arbiter
   import stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   stream_merge_arbiter_if.slave  bus
);

   merge_state_e          state_reg;
   logic [1:0]            eos_seen_reg;
   logic                  out_valid_reg;
   logic                  out_eos_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;
`ifdef STREAM_MERGE_SRC_TAG_EN
   logic                  out_src_reg;
`endif

   logic [1:0]            in_valid;
   logic [1:0]            in_eos;
   logic [1:0]            in_ready;
   logic [1:0]            req;
   logic [1:0]            accept;
   logic [DATA_WIDTH-1:0] in_data [2];
   logic                  grant;
   logic                  drain;
   logic                  out_fire;
   logic                  in_run;

   assign in_valid   = {bus.in1_valid, bus.in0_valid};
   assign in_eos     = {bus.in1_data_field1, bus.in0_data_field1};
   assign in_data[0] = bus.in0_data_field0;
   assign in_data[1] = bus.in1_data_field0;

   assign in_run   = (state_reg == ST_RUN);
   assign out_fire = out_valid_reg && bus.out0_ready;
   // The output register can take a new beat when empty or being drained this cycle.
   assign drain    = !out_valid_reg || bus.out0_ready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_in
         assign req[gi]      = in_run && !eos_seen_reg[gi] && in_valid[gi];
         assign in_ready[gi] = in_run && !eos_seen_reg[gi] && (grant == 1'(gi)) && drain;
         assign accept[gi]   = in_valid[gi] && in_ready[gi];
      end
   endgenerate

   rr_arbiter2 u_arb (
      .clock  (clock),
      .reset  (reset),
      .clear  (!in_run),
      .req    (req),
      .accept (|accept),
      .grant  (grant)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         eos_seen_reg  <= 2'b00;
         out_valid_reg <= 1'b0;
         out_eos_reg   <= 1'b0;
         out_data_reg  <= '0;
`ifdef STREAM_MERGE_SRC_TAG_EN
         out_src_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.inCtrl_valid) begin
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (eos_seen_reg == 2'b11 && drain) begin
                  state_reg     <= ST_EMIT_EOS;
                  out_valid_reg <= 1'b1;
                  out_eos_reg   <= 1'b1;
                  out_data_reg  <= '0;
`ifdef STREAM_MERGE_SRC_TAG_EN
                  out_src_reg   <= 1'b0;
`endif
               end else if (|accept && !in_eos[grant]) begin
                  out_valid_reg <= 1'b1;
                  out_eos_reg   <= 1'b0;
                  out_data_reg  <= in_data[grant];
`ifdef STREAM_MERGE_SRC_TAG_EN
                  out_src_reg   <= grant;
`endif
               end else if (out_fire) begin
                  out_valid_reg <= 1'b0;
               end
               // An input EOS is swallowed here; the merged EOS is generated once both have ended.
               if (|accept && in_eos[grant]) begin
                  eos_seen_reg[grant] <= 1'b1;
               end
            end
            ST_EMIT_EOS: begin
               if (out_fire) begin
                  out_valid_reg <= 1'b0;
                  out_eos_reg   <= 1'b0;
                  state_reg     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.outCtrl_ready) begin
                  state_reg    <= ST_IDLE;
                  eos_seen_reg <= 2'b00;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.inCtrl_ready     = (state_reg == ST_IDLE);
   assign bus.outCtrl_valid    = (state_reg == ST_DONE);
   assign bus.in0_ready        = in_ready[0];
   assign bus.in1_ready        = in_ready[1];
   assign bus.out0_valid       = out_valid_reg;
   assign bus.out0_data_field0 = out_data_reg;
   assign bus.out0_data_field1 = out_eos_reg;
`ifdef STREAM_MERGE_SRC_TAG_EN
   assign bus.out0_data_src    = out_src_reg;
`endif

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Directed bench for stream_merge_arbiter with a queue-based reference model checked every cycle.
// Honours STREAM_MERGE_SRC_TAG_EN when checking the source tag.
module tb_stream_merge_arbiter;

   localparam int DW = 64;
   localparam logic [1:0] P_IDLE = 2'd0, P_RUN = 2'd1, P_EMIT = 2'd2, P_DONE = 2'd3;
   localparam logic [64:0] EOS = {1'b1, 64'd0};

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   stream_merge_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   stream_merge_arbiter #(.DATA_WIDTH(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   logic dut_src;
`ifdef STREAM_MERGE_SRC_TAG_EN
   assign dut_src = bus.out0_data_src;
   localparam logic [65:0] MASK = '1;
`else
   assign dut_src = 1'b0;
   localparam logic [65:0] MASK = {1'b0, {65{1'b1}}};
`endif

   int total = 0;
   int bad   = 0;

   logic [64:0] q0[$], q1[$];          // pending input beats {eos, data}
   logic        tx0 = 1'b0, tx1 = 1'b0;
   logic [65:0] mq[$];                 // model: accepted beats not yet delivered {src, eos, data}
   logic [65:0] seen[$], exp_q[$];     // DUT output log and literal expectations
   logic [1:0]  meos = 2'b00;
   logic        mptr = 1'b0;
   logic [1:0]  ph   = P_IDLE;
   int          ctrl_beats = 0;

   logic [65:0] m_cur;
   logic        m_full, m_drain, m_req0, m_req1, m_win, m_er0, m_er1, m_ofire, m_emit;
   logic [1:0]  m_ph_old;

   function automatic logic [64:0] el(input logic [63:0] v);
      return {1'b0, v};
   endfunction

   function automatic logic [65:0] ex(input logic src, input logic eos, input logic [63:0] v);
      return {src, eos, v};
   endfunction

   task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0b expected=%0b", name, got, exp);
      end
   endtask

   task automatic chki(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Stream drivers: present the head of each queue, pop it after an observed handshake.
   initial begin
      bus.in0_valid = 1'b0; bus.in0_data_field0 = '0; bus.in0_data_field1 = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (tx0 && q0.size() > 0) void'(q0.pop_front());
         if (q0.size() > 0) begin
            bus.in0_valid = 1'b1;
            {bus.in0_data_field1, bus.in0_data_field0} = q0[0];
         end else begin
            bus.in0_valid = 1'b0;
            {bus.in0_data_field1, bus.in0_data_field0} = '0;
         end
      end
   end

   initial begin
      bus.in1_valid = 1'b0; bus.in1_data_field0 = '0; bus.in1_data_field1 = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (tx1 && q1.size() > 0) void'(q1.pop_front());
         if (q1.size() > 0) begin
            bus.in1_valid = 1'b1;
            {bus.in1_data_field1, bus.in1_data_field0} = q1[0];
         end else begin
            bus.in1_valid = 1'b0;
            {bus.in1_data_field1, bus.in1_data_field0} = '0;
         end
      end
   end

   // Reference model and per-cycle compare; all decisions apply to the coming rising edge.
   always @(negedge clock) begin
      m_cur = {dut_src, bus.out0_data_field1, bus.out0_data_field0};
      tx0 = bus.in0_valid && bus.in0_ready;
      tx1 = bus.in1_valid && bus.in1_ready;
      if (!reset) begin
         chk1("rst_out0_valid", bus.out0_valid, 1'b0);
         chk1("rst_outCtrl_valid", bus.outCtrl_valid, 1'b0);
         chk1("rst_inCtrl_ready", bus.inCtrl_ready, 1'b1);
         chk1("rst_in0_ready", bus.in0_ready, 1'b0);
         chk1("rst_in1_ready", bus.in1_ready, 1'b0);
         mq.delete();
         meos = 2'b00;
         mptr = 1'b0;
         ph   = P_IDLE;
      end else begin
         m_full  = (mq.size() != 0);
         m_drain = !m_full || bus.out0_ready;
         m_req0  = (ph == P_RUN) && !meos[0] && bus.in0_valid;
         m_req1  = (ph == P_RUN) && !meos[1] && bus.in1_valid;
         m_win   = (m_req0 && m_req1) ? mptr : m_req1;
         m_er0   = m_req0 && !m_win && m_drain;
         m_er1   = m_req1 && m_win && m_drain;

         chk1("inCtrl_ready", bus.inCtrl_ready, ph == P_IDLE);
         chk1("outCtrl_valid", bus.outCtrl_valid, ph == P_DONE);
         chk1("out0_valid", bus.out0_valid, m_full);
         if (m_full && bus.out0_valid) chk("out0_beat", m_cur & MASK, mq[0] & MASK);
         if (bus.in0_valid) chk1("in0_ready", bus.in0_ready, m_er0);
         if (bus.in1_valid) chk1("in1_ready", bus.in1_ready, m_er1);

         m_ofire  = m_full && bus.out0_ready;
         m_emit   = (ph == P_RUN) && (meos == 2'b11) && m_drain;
         m_ph_old = ph;

         if (bus.out0_valid && bus.out0_ready) seen.push_back(m_cur);
         if (bus.outCtrl_valid && bus.outCtrl_ready) ctrl_beats++;

         if (m_ofire) begin
            if (mq[0][64]) ph = P_DONE;
            void'(mq.pop_front());
         end
         if (m_er0) begin
            if (bus.in0_data_field1) meos[0] = 1'b1;
            else mq.push_back({1'b0, 1'b0, bus.in0_data_field0});
            mptr = 1'b1;
         end
         if (m_er1) begin
            if (bus.in1_data_field1) meos[1] = 1'b1;
            else mq.push_back({1'b1, 1'b0, bus.in1_data_field0});
            mptr = 1'b0;
         end
         if (m_emit) begin
            mq.push_back({1'b0, 1'b1, 64'd0});
            ph = P_EMIT;
         end
         if (m_ph_old == P_DONE && bus.outCtrl_ready) begin
            ph   = P_IDLE;
            meos = 2'b00;
            mptr = 1'b0;
         end
         if (m_ph_old == P_IDLE && bus.inCtrl_valid) ph = P_RUN;
      end
   end

   task automatic start_run(input int extra);
      int n;
      @(posedge clock); #1;
      bus.inCtrl_valid = 1'b1;
      n = 0;
      do begin @(negedge clock); #1; n++; end while (ph == P_IDLE && n < 20);
      chk1("start_accepted", ph != P_IDLE, 1'b1);
      repeat (extra) @(posedge clock);
      @(posedge clock); #1;
      bus.inCtrl_valid = 1'b0;
   endtask

   task automatic wait_phase(input string name, input logic [1:0] target);
      int n;
      n = 0;
      while (ph != target && n < 300) begin @(negedge clock); #1; n++; end
      chk1({name, "_reached"}, ph == target, 1'b1);
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      do begin @(negedge clock); #1; n++; end while (!bus.out0_valid && n < 50);
      chk1({name, "_out_valid"}, bus.out0_valid, 1'b1);
   endtask

   task automatic compare_seen(input string name);
      int n;
      chki({name, "_beats"}, seen.size(), exp_q.size());
      n = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_beat%0d", name, i), seen[i] & MASK, exp_q[i] & MASK);
      end
   endtask

   task automatic clear_logs();
      seen.delete();
      exp_q.delete();
      ctrl_beats = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end

   initial begin
      bus.inCtrl_valid  = 1'b0;
      bus.outCtrl_ready = 1'b1;
      bus.out0_ready    = 1'b1;
      repeat (3) @(posedge clock);
      #3;
      chk1("init_out0_valid", bus.out0_valid, 1'b0);
      chk("init_out0_data", {1'b0, bus.out0_data_field1, bus.out0_data_field0}, 66'd0);
      chk1("init_inCtrl_ready", bus.inCtrl_ready, 1'b1);
      reset = 1'b1;
      repeat (2) @(posedge clock);

      // Basic run, start token held into RUN, completion token back-pressured.
      clear_logs();
      bus.outCtrl_ready = 1'b0;
      q0 = '{el(64'd5), el(64'd7), EOS};
      q1 = '{EOS};
      start_run(3);
      wait_phase("a_done", P_DONE);
      repeat (3) begin
         @(negedge clock); #1;
         chk1("a_outCtrl_hold", bus.outCtrl_valid, 1'b1);
      end
      @(posedge clock); #1;
      bus.outCtrl_ready = 1'b1;
      wait_phase("a_idle", P_IDLE);
      exp_q = '{ex(0, 0, 64'd5), ex(0, 0, 64'd7), ex(0, 1, 64'd0)};
      compare_seen("a");
      chki("a_ctrl_beats", ctrl_beats, 1);

      // Both streams valid every cycle: strict alternation.
      clear_logs();
      q0 = '{el(64'd10), el(64'd11), el(64'd12), EOS};
      q1 = '{el(64'd20), el(64'd21), el(64'd22), EOS};
      start_run(0);
      wait_phase("b_idle", P_IDLE);
      exp_q = '{ex(0, 0, 64'd10), ex(1, 0, 64'd20), ex(0, 0, 64'd11), ex(1, 0, 64'd21),
                ex(0, 0, 64'd12), ex(1, 0, 64'd22), ex(0, 1, 64'd0)};
      compare_seen("b");
      chki("b_ctrl_beats", ctrl_beats, 1);

      // Output stall with 42 held.
      clear_logs();
      bus.out0_ready = 1'b0;
      q0 = '{el(64'd42), EOS};
      q1 = '{EOS};
      start_run(0);
      wait_out_valid("c");
      repeat (4) begin
         @(negedge clock); #1;
         chk1("c_hold_valid", bus.out0_valid, 1'b1);
         chk("c_hold_data", {2'b00, bus.out0_data_field0}, 66'd42);
         chk1("c_hold_in0_ready", bus.in0_ready, 1'b0);
         chk1("c_hold_in1_ready", bus.in1_ready, 1'b0);
      end
      @(posedge clock); #1;
      bus.out0_ready = 1'b1;
      wait_phase("c_idle", P_IDLE);
      exp_q = '{ex(0, 0, 64'd42), ex(0, 1, 64'd0)};
      compare_seen("c");

      // Data after an input's EOS stays stalled.
      clear_logs();
      q0 = '{el(64'd1), el(64'd2), EOS};
      q1 = '{EOS, el(64'd99)};
      start_run(0);
      wait_phase("d_idle", P_IDLE);
      exp_q = '{ex(0, 0, 64'd1), ex(0, 0, 64'd2), ex(0, 1, 64'd0)};
      compare_seen("d");
      chki("d_in1_pending", q1.size(), 1);
      if (q1.size() > 0) chk("d_in1_head", {1'b0, q1[0]}, {1'b0, el(64'd99)});
      q1.delete();
      repeat (2) @(posedge clock);

      // Reset mid-run with 3 held, then a clean run.
      clear_logs();
      bus.out0_ready = 1'b0;
      q0 = '{el(64'd3), EOS};
      q1 = '{EOS};
      start_run(0);
      wait_out_valid("e");
      @(posedge clock); #3;
      reset = 1'b0;
      #1;
      chk1("e_async_drop", bus.out0_valid, 1'b0);
      q0.delete();
      q1.delete();
      bus.out0_ready = 1'b1;
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b1;
      clear_logs();
      repeat (10) @(negedge clock);
      #1;
      chki("e_post_reset_beats", seen.size(), 0);
      chki("e_post_reset_ctrl", ctrl_beats, 0);
      q0 = '{el(64'd7), EOS};
      q1 = '{el(64'd8), EOS};
      start_run(0);
      wait_phase("e_idle", P_IDLE);
      exp_q = '{ex(0, 0, 64'd7), ex(1, 0, 64'd8), ex(0, 1, 64'd0)};
      compare_seen("e");
      chki("e_ctrl_beats", ctrl_beats, 1);

      repeat (3) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
